// File: rtl/mult_repeated_add_param_pkg.sv
// Shared types and helpers for the repeated-addition multiplier.
package mult_repeated_add_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Magnitude of a width-bit value held in the low bits of val. In signed
  // mode the most negative value maps to 2^(width-1), which still fits.
  function automatic logic [63:0] abs_mag(input logic [63:0] val,
                                          input int width,
                                          input logic is_signed);
    logic [63:0] mask;
    logic        msb;
    mask = (64'd1 << width) - 64'd1;
    msb  = val[6'(width - 1)];
    if (is_signed && msb) abs_mag = (~val + 64'd1) & mask;
    else                  abs_mag = val & mask;
  endfunction

endpackage

// File: rtl/mult_repeated_add_param_if.sv
// Operand/result bus of the repeated-addition multiplier.
interface mult_repeated_add_param_if
  import mult_repeated_add_param_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int OUT_WIDTH = 2 * WIDTH;

  // Handshake: operands transfer on a rising edge with valid_in && ready_in;
  // the result transfers on a rising edge with valid_out && ready_out. While
  // valid_out is high and ready_out is low, mult_out and valid_out hold.
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 signed_mode;
  logic                 valid_in;
  logic                 ready_in;
  logic                 ready_out;
  logic [OUT_WIDTH-1:0] mult_out;
  logic                 valid_out;
  mult_state_t          state_dbg;

  modport master (
    output in_a, in_b, signed_mode, valid_in, ready_out,
    input  ready_in, mult_out, valid_out, state_dbg
  );

  modport slave (
    input  in_a, in_b, signed_mode, valid_in, ready_out,
    output ready_in, mult_out, valid_out, state_dbg
  );
endinterface

// File: rtl/mult_repeated_add_param_operand_prep.sv
// Converts operands to magnitudes, derives the result sign and picks the
// smaller magnitude as loop count so the add loop finishes early.
module mult_repeated_add_param_operand_prep
  import mult_repeated_add_param_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] count,
  output logic             neg
);
  logic             is_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    is_signed = signed_mode & SIGNED_SUPPORT;
    mag_a     = WIDTH'(abs_mag(64'(a), WIDTH, is_signed));
    mag_b     = WIDTH'(abs_mag(64'(b), WIDTH, is_signed));
    neg       = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    if (mag_a >= mag_b) begin
      addend = mag_a;
      count  = mag_b;
    end else begin
      addend = mag_b;
      count  = mag_a;
    end
  end
endmodule

// File: rtl/mult_repeated_add_param.sv
// Low-area handshaked multiplier: product by repeated addition of the larger
// magnitude, sign applied once at the end. WIDTH must match the bus WIDTH.
module mult_repeated_add_param
  import mult_repeated_add_param_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  mult_repeated_add_param_if.slave  bus
);
  localparam int OUT_WIDTH = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]           state;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] addend_q;
  logic [WIDTH-1:0]     cnt;
  logic                 neg_q;
  logic [OUT_WIDTH-1:0] mult_q;
  logic                 valid_q;

  logic [WIDTH-1:0]     prep_addend;
  logic [WIDTH-1:0]     prep_count;
  logic                 prep_neg;

  mult_repeated_add_param_operand_prep #(
    .WIDTH          (WIDTH),
    .SIGNED_SUPPORT (SIGNED_SUPPORT)
  ) u_prep (
    .a           (bus.in_a),
    .b           (bus.in_b),
    .signed_mode (bus.signed_mode),
    .addend      (prep_addend),
    .count       (prep_count),
    .neg         (prep_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      addend_q <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      mult_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.valid_in) begin
            addend_q <= OUT_WIDTH'(prep_addend);
            cnt      <= prep_count;
            neg_q    <= prep_neg;
            acc      <= '0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          // The accumulator is twice the operand width, so even the largest
          // magnitude product cannot wrap.
          if (cnt != '0) begin
            acc <= acc + addend_q;
            cnt <= cnt - 1'b1;
          end else begin
            mult_q  <= neg_q ? -acc : acc;
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ready_out) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_in  = (state == ST_IDLE);
  assign bus.mult_out  = mult_q;
  assign bus.valid_out = valid_q;
  assign bus.state_dbg = mult_state_t'(state);
endmodule

// File: tb/tb_mult_repeated_add_param.sv
// Bench for mult_repeated_add_param: a WIDTH=4 and a WIDTH=8 instance, driven
// with directed and random operands, checked by a queue-based scoreboard.
module tb_mult_repeated_add_param;
  import mult_repeated_add_param_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_repeated_add_param_if #(.WIDTH(4)) if4 ();
  mult_repeated_add_param_if #(.WIDTH(8)) if8 ();

  mult_repeated_add_param #(.WIDTH(4), .SIGNED_SUPPORT(1'b1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  mult_repeated_add_param #(.WIDTH(8), .SIGNED_SUPPORT(1'b1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_val4[$];
  logic [15:0] exp_val8[$];
  int          exp_cyc4[$];
  int          exp_cyc8[$];
  bit          in_prog[2];
  logic [15:0] held[2];
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (width %0d): got %0h expected %0h", name, d ? 8 : 4, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: plain integer multiply of the interpreted operands.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input bit sm, output logic [15:0] prod, output int lat);
    longint ai, bi, ma, mb, p;
    ai = longint'(a);
    bi = longint'(b);
    if (sm) begin
      if (ai >= (64'sd1 <<< (w - 1))) ai = ai - (64'sd1 <<< w);
      if (bi >= (64'sd1 <<< (w - 1))) bi = bi - (64'sd1 <<< w);
    end
    p    = ai * bi;
    prod = 16'(p);
    if (w == 4) prod[15:8] = 8'h00;
    ma   = (ai < 0) ? -ai : ai;
    mb   = (bi < 0) ? -bi : bi;
    lat  = int'(((ma < mb) ? ma : mb) + 1);
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                       input bit sm, input bit track);
    logic [15:0] p;
    int          lat;
    int          guard;
    guard = 0;
    while ((d == 0 ? if4.ready_in : if8.ready_in) !== 1'b1) begin
      step();
      guard++;
      if (guard > 600) begin
        n_vec++;
        n_err++;
        $display("FAIL ready_in_timeout (width %0d): ready_in stayed low", d ? 8 : 4);
        return;
      end
    end
    if (d == 0) begin
      if4.in_a = a[3:0]; if4.in_b = b[3:0]; if4.signed_mode = sm; if4.valid_in = 1'b1;
    end else begin
      if8.in_a = a; if8.in_b = b; if8.signed_mode = sm; if8.valid_in = 1'b1;
    end
    @(posedge clk);
    #1;
    // Scramble operands after the accept edge; the DUT must not resample them.
    if (d == 0) begin
      if4.valid_in = 1'b0; if4.in_a = 4'($urandom); if4.in_b = 4'($urandom);
      check("accept_ready_in_low", d, if4.ready_in, 0);
    end else begin
      if8.valid_in = 1'b0; if8.in_a = 8'($urandom); if8.in_b = 8'($urandom);
      check("accept_ready_in_low", d, if8.ready_in, 0);
    end
    if (track) begin
      model(d == 0 ? 4 : 8, a, b, sm, p, lat);
      if (d == 0) begin exp_val4.push_back(p); exp_cyc4.push_back(cyc + lat); end
      else        begin exp_val8.push_back(p); exp_cyc8.push_back(cyc + lat); end
    end
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while (((d == 0) ? exp_val4.size() : exp_val8.size()) != 0 || in_prog[d]) begin
      step();
      guard++;
      if (guard > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout (width %0d): result never delivered", d ? 8 : 4);
        return;
      end
    end
  endtask

  // ---------------- monitor ----------------
  // At a falling edge, ready_out still holds the value seen by the previous
  // rising edge, so it tells whether a result handshake just happened.
  task automatic monitor(input int d, input logic vo, input logic ri,
                         input logic ro, input logic [15:0] mo);
    logic [15:0] ev;
    int          ec;
    if (rst) begin
      in_prog[d] = 1'b0;
      return;
    end
    if (in_prog[d]) begin
      if (ro) begin
        check("handshake_valid_drop", d, vo, 0);
        check("handshake_ready_in", d, ri, 1);
        check("handshake_out_kept", d, mo, held[d]);
        in_prog[d] = 1'b0;
      end else begin
        check("backpressure_valid_held", d, vo, 1);
        check("backpressure_out_held", d, mo, held[d]);
        check("backpressure_ready_in", d, ri, 0);
      end
    end else if (vo) begin
      if (((d == 0) ? exp_val4.size() : exp_val8.size()) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output (width %0d): got %0h with nothing expected", d ? 8 : 4, mo);
      end else begin
        if (d == 0) begin ev = exp_val4.pop_front(); ec = exp_cyc4.pop_front(); end
        else        begin ev = exp_val8.pop_front(); ec = exp_cyc8.pop_front(); end
        check("product", d, mo, ev);
        check("latency_edge", d, cyc, ec);
        check("result_ready_in_low", d, ri, 0);
      end
      held[d]    = ev;
      in_prog[d] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    monitor(0, if4.valid_out, if4.ready_in, if4.ready_out, 16'(if4.mult_out));
    monitor(1, if8.valid_out, if8.ready_in, if8.ready_out, if8.mult_out);
  end

  initial begin
    forever begin
      step();
      if (rand_bp) begin
        if4.ready_out = ($urandom_range(0, 3) != 0);
        if8.ready_out = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    if4.in_a = '0; if4.in_b = '0; if4.signed_mode = 1'b0; if4.valid_in = 1'b0; if4.ready_out = 1'b1;
    if8.in_a = '0; if8.in_b = '0; if8.signed_mode = 1'b0; if8.valid_in = 1'b0; if8.ready_out = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check("reset_valid_out", 0, if4.valid_out, 0);
    check("reset_mult_out", 0, if4.mult_out, 0);
    check("reset_ready_in", 0, if4.ready_in, 1);
    check("reset_state", 0, if4.state_dbg, IDLE);
    check("reset_valid_out", 1, if8.valid_out, 0);
    check("reset_ready_in", 1, if8.ready_in, 1);
    rst = 1'b0;
    step();

    // Directed, width 4
    issue(0, 8'h5, 8'h2, 1'b0, 1'b1);
    issue(0, 8'h2, 8'hF, 1'b0, 1'b1);
    issue(0, 8'h0, 8'h9, 1'b0, 1'b1);
    issue(0, 8'hD, 8'h5, 1'b1, 1'b1);
    issue(0, 8'h8, 8'h8, 1'b1, 1'b1);
    issue(0, 8'h8, 8'h8, 1'b0, 1'b1);
    wait_idle(0);

    // Backpressure with an ignored valid_in while holding the result
    if4.ready_out = 1'b0;
    issue(0, 8'h3, 8'h3, 1'b0, 1'b1);
    guard = 0;
    while (if4.valid_out !== 1'b1 && guard < 50) begin step(); guard++; end
    if4.in_a = 4'h7; if4.in_b = 4'h7; if4.valid_in = 1'b1;
    repeat (5) step();
    if4.valid_in = 1'b0;
    if4.ready_out = 1'b1;
    wait_idle(0);

    // Reset at the 4th CALC edge of a long transaction
    issue(0, 8'hF, 8'hF, 1'b0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midcalc_reset_valid_out", 0, if4.valid_out, 0);
    check("midcalc_reset_mult_out", 0, if4.mult_out, 0);
    check("midcalc_reset_ready_in", 0, if4.ready_in, 1);
    issue(0, 8'h3, 8'h4, 1'b0, 1'b1);
    wait_idle(0);

    // Directed, width 8
    issue(1, 8'd200, 8'd3, 1'b0, 1'b1);
    issue(1, 8'h80, 8'hFF, 1'b1, 1'b1);
    wait_idle(1);

    // Random operands and mode under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++)
      issue(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    wait_idle(0);
    for (int i = 0; i < 25; i++)
      issue(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    wait_idle(1);
    rand_bp = 1'b0;
    step();
    if4.ready_out = 1'b1;
    if8.ready_out = 1'b1;
    repeat (3) step();

    check("queue_drained", 0, exp_val4.size() + exp_val8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
